// File: rtl/mf_phase_ctrl_pkg.sv
// Shared types and default constants for the matched-filter phase controller.
package mf_phase_ctrl_pkg;

  localparam int unsigned NUM_PH_D = 4;
  localparam int unsigned ERR_W_D  = 56;

  typedef logic [$clog2(NUM_PH_D)-1:0] phase_t;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeas,
    StLockSettle,
    StLock
  } state_e;

endpackage

// File: rtl/mf_phase_ctrl_lock_monitor.sv
// Loss-of-lock monitor: compares each tracked window against a shifted copy of
// the locked error and counts consecutive over-threshold windows.
module lock_monitor #(
  parameter int unsigned ERR_W      = 56,
  parameter int unsigned LOSS_SHIFT = 1,
  parameter int unsigned LOSS_CNT   = 2
) (
  input  logic             i_sys_clk,
  input  logic             i_reset_n,
  input  logic             i_arm,
  input  logic             i_win,
  input  logic [ERR_W-1:0] i_err,
  input  logic [ERR_W-1:0] i_best_err,
  output logic             o_loss,
  output logic [7:0]       o_relock_cnt
);

  localparam int unsigned EXT_W = ERR_W + LOSS_SHIFT;
  localparam int unsigned CNT_W = $clog2(LOSS_CNT + 1);

  logic [EXT_W-1:0] w_thr;
  logic [EXT_W-1:0] w_err_ext;
  logic             w_over;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_relock_cnt;

  // Threshold is widened so the shift can never overflow.
  always_comb begin
    w_thr     = EXT_W'(i_best_err) << LOSS_SHIFT;
    w_err_ext = EXT_W'(i_err);
    w_over    = w_err_ext > w_thr;
    o_loss    = i_arm && i_win && w_over && (r_cnt == CNT_W'(LOSS_CNT - 1));
  end

  // Consecutive over-threshold counter and saturating loss-event counter.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt        <= '0;
      r_relock_cnt <= '0;
    end else begin
      if (!i_arm) begin
        r_cnt <= '0;
      end else if (i_win) begin
        if (w_over && !o_loss) r_cnt <= r_cnt + 1'b1;
        else                   r_cnt <= '0;
      end
      if (o_loss && (r_relock_cnt != 8'hFF)) r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign o_relock_cnt = r_relock_cnt;

endmodule

// File: rtl/mf_phase_ctrl.sv
// Symbol-timing phase controller: sweeps the tap select over all phases,
// locks onto the least-error phase and restarts the sweep on loss of lock.
module mf_phase_ctrl
  import mf_phase_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PH     = NUM_PH_D,
  parameter int unsigned ERR_W      = ERR_W_D,
  parameter int unsigned SETTLE_WIN = 1,
  parameter int unsigned LOSS_SHIFT = 1,
  parameter int unsigned LOSS_CNT   = 2
) (
  input  logic                      i_sys_clk,
  input  logic                      i_reset_n,
  input  logic                      i_cycle,
  input  logic [ERR_W-1:0]          i_err_square,
  input  logic                      i_start,
  input  logic                      i_manual_en,
  input  logic [$clog2(NUM_PH)-1:0] i_manual_ph,
  output logic [$clog2(NUM_PH)-1:0] o_phase_sel,
  output logic                      o_busy,
  output logic                      o_locked,
  output logic                      o_done,
  output logic [ERR_W-1:0]          o_best_err,
  output logic [7:0]                o_relock_cnt
);

  localparam int unsigned PH_W   = $clog2(NUM_PH);
  localparam int unsigned SKIP_W = $clog2(SETTLE_WIN + 2);

  state_e            r_state;
  logic              r_win_v;
  logic [SKIP_W-1:0] r_skip;
  logic [ERR_W-1:0]  r_run_err;
  logic [PH_W-1:0]   r_run_ph;
  logic [PH_W-1:0]   r_phase_sel;
  logic              r_busy;
  logic              r_locked;
  logic              r_done;
  logic [ERR_W-1:0]  r_best_err;

  logic              w_take;
  logic [ERR_W-1:0]  w_new_err;
  logic [PH_W-1:0]   w_new_ph;
  logic              w_arm;
  logic              w_loss;
  state_e            w_search_st;
  state_e            w_lock_st;

  // Running-best update; strict compare keeps the lower phase on a tie.
  always_comb begin
    w_take    = (r_phase_sel == '0) || (i_err_square < r_run_err);
    w_new_err = w_take ? i_err_square : r_run_err;
    w_new_ph  = w_take ? r_phase_sel : r_run_ph;
    w_arm     = (r_state == StLock) && !i_manual_en;
    if (SETTLE_WIN == 0) begin
      w_search_st = StMeas;
      w_lock_st   = StLock;
    end else begin
      w_search_st = StSettle;
      w_lock_st   = StLockSettle;
    end
  end

  // Window strobe: err_square is valid one clock after cycle.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_win_v <= 1'b0;
    else            r_win_v <= i_cycle;
  end

  // Search/lock FSM with registered outputs; manual_en overrides everything.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_skip      <= '0;
      r_run_err   <= '0;
      r_run_ph    <= '0;
      r_phase_sel <= '0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_best_err  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_manual_en) begin
        r_state     <= StIdle;
        r_phase_sel <= i_manual_ph;
        r_busy      <= 1'b0;
        r_locked    <= 1'b0;
        r_skip      <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_phase_sel <= '0;
              r_busy      <= 1'b1;
              r_skip      <= SKIP_W'(SETTLE_WIN);
              r_state     <= w_search_st;
            end
          end
          StSettle: begin
            if (r_win_v) begin
              if (r_skip <= SKIP_W'(1)) begin
                r_skip  <= '0;
                r_state <= StMeas;
              end else begin
                r_skip <= r_skip - 1'b1;
              end
            end
          end
          StMeas: begin
            if (r_win_v) begin
              r_run_err <= w_new_err;
              r_run_ph  <= w_new_ph;
              r_skip    <= SKIP_W'(SETTLE_WIN);
              if (r_phase_sel != PH_W'(NUM_PH - 1)) begin
                r_phase_sel <= r_phase_sel + 1'b1;
                r_state     <= w_search_st;
              end else begin
                r_phase_sel <= w_new_ph;
                r_best_err  <= w_new_err;
                r_busy      <= 1'b0;
                r_locked    <= 1'b1;
                r_done      <= 1'b1;
                r_state     <= w_lock_st;
              end
            end
          end
          StLockSettle: begin
            if (r_win_v) begin
              if (r_skip <= SKIP_W'(1)) begin
                r_skip  <= '0;
                r_state <= StLock;
              end else begin
                r_skip <= r_skip - 1'b1;
              end
            end
          end
          StLock: begin
            if (w_loss || i_start) begin
              r_phase_sel <= '0;
              r_busy      <= 1'b1;
              r_locked    <= 1'b0;
              r_skip      <= SKIP_W'(SETTLE_WIN);
              r_state     <= w_search_st;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  lock_monitor #(
    .ERR_W      (ERR_W),
    .LOSS_SHIFT (LOSS_SHIFT),
    .LOSS_CNT   (LOSS_CNT)
  ) u_lock_monitor (
    .i_sys_clk    (i_sys_clk),
    .i_reset_n    (i_reset_n),
    .i_arm        (w_arm),
    .i_win        (r_win_v),
    .i_err        (i_err_square),
    .i_best_err   (r_best_err),
    .o_loss       (w_loss),
    .o_relock_cnt (o_relock_cnt)
  );

  assign o_phase_sel = r_phase_sel;
  assign o_busy      = r_busy;
  assign o_locked    = r_locked;
  assign o_done      = r_done;
  assign o_best_err  = r_best_err;

endmodule

// File: doc/mf_phase_ctrl.md
# mf_phase_ctrl

Symbol-timing phase controller for the receive matched-filter path. It steps the matched-filter delay-tap select through all sample phases and measures the windowed squared error at each one. It then locks onto the phase with the least error and monitors that phase for loss of lock. The block sits between the squared-error averager (`err_square`, window strobe `cycle`) and the decision-variable tap multiplexer, replacing the static `SW[17:16]` select.

## Interface
- `NUM_PH`, default 4: number of selectable sample phases; `phase_sel` width is `clog2(NUM_PH)`.
- `ERR_W`, default 56: width of `err_square`.
- `SETTLE_WIN`, default 1: measurement windows discarded after every phase change.
- `LOSS_SHIFT`, default 1: loss threshold is `best_err << LOSS_SHIFT`.
- `LOSS_CNT`, default 2: consecutive over-threshold windows that declare loss of lock.
- `sys_clk`, in, 1: system clock; single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cycle`, in, 1: one-`sys_clk` pulse marking the end of a measurement window.
- `err_square`, in, `ERR_W`: unsigned accumulated squared error; valid one `sys_clk` after `cycle`.
- `start`, in, 1: one-cycle request to begin a search.
- `manual_en`, in, 1: level; forces the manual phase.
- `manual_ph`, in, `clog2(NUM_PH)`: phase used while `manual_en` = 1.
- `phase_sel`, out, `clog2(NUM_PH)`: registered tap select driven to the decision-variable mux.
- `busy`, out, 1: high while a search is in progress.
- `locked`, out, 1: high while tracking the best phase.
- `done`, out, 1: one-cycle pulse when a search completes.
- `best_err`, out, `ERR_W`: error measured at the locked phase.
- `relock_cnt`, out, 8: number of loss-of-lock events; saturates at 255.

## Operation
- States: IDLE, SETTLE, MEAS, LOCK_SETTLE, LOCK.
- Window sample: `win_v` = `cycle` delayed by one `sys_clk`. `err_square` is captured on `win_v`.
- IDLE, on `start`: `phase_sel` ← 0, `busy` ← 1, skip counter ← `SETTLE_WIN`, next state SETTLE.
- SETTLE: each `win_v` decrements the skip counter. At 0, go to MEAS. If `SETTLE_WIN` = 0, go straight to MEAS.
- MEAS, on `win_v`:
  - For phase 0, or when `err_square` < the running best, update best error and best phase. Comparison is strict, so a tie keeps the lower phase.
  - If `phase_sel` < `NUM_PH`-1: increment `phase_sel`, reload the skip counter, go to SETTLE.
  - Otherwise: `phase_sel` ← best phase, `best_err` ← best error, `busy` ← 0, `locked` ← 1, `done` pulses, next state LOCK_SETTLE.
- LOCK_SETTLE: discard `SETTLE_WIN` windows, then go to LOCK.
- LOCK, on `win_v`:
  - Over-threshold window (`err_square` > threshold): loss counter increments.
  - Any other window: loss counter clears.
  - Threshold is computed at `ERR_W`+`LOSS_SHIFT` bits; no saturation is needed.
  - When the loss counter reaches `LOSS_CNT`: `relock_cnt`++, `locked` ← 0, restart the search exactly as `start` does.
- `start` in LOCK: restarts the search. `start` in SETTLE or MEAS: ignored.
- `manual_en` = 1, in any state:
  - Next edge: state IDLE, `phase_sel` ← `manual_ph` (tracks it every cycle), `busy` = 0, `locked` = 0.
  - `start` is ignored.
  - `best_err` and `relock_cnt` are held.
- `manual_en` falling: remain in IDLE, and `phase_sel` keeps its last value.

## Timing
- Reset values: `phase_sel` 0, `busy` 0, `locked` 0, `done` 0, `best_err` 0, `relock_cnt` 0, state IDLE, counters 0.
- `start` high at edge N: `busy` and `phase_sel` = 0 are visible after edge N.
- All state updates happen on the `win_v` edge, which is 1 `sys_clk` after `cycle`.
- Search length is `NUM_PH`×(`SETTLE_WIN`+1) windows. With defaults this is 8 windows.
- `done` and `locked` rise on the same edge as the final `phase_sel` update.
- Simultaneous events:
  - `start` and `win_v` in IDLE: `start` wins, and that window is not counted.
  - `manual_en` and anything else: `manual_en` wins.
  - Loss detection and `start` on the same edge: `relock_cnt` still increments.
- Reset mid-search: all outputs return to their reset values asynchronously. No partial results are retained.

## Structure
- `mf_phase_ctrl_pkg` holds:
  - the state enum;
  - default constants `NUM_PH_D`, `ERR_W_D`;
  - a `phase_t` typedef.
- Sub-module `lock_monitor`: threshold shift, compare, consecutive-loss counter and `relock_cnt` saturation.
- The FSM, window-strobe delay, and best-tracking registers live in `mf_phase_ctrl`.

## Test plan
- Defaults; `start`; per-phase errors 900, 400, 100, 700 → `phase_sel` = 2, `best_err` = 100, `done` pulses once after window 8, `locked` = 1.
- Tie test: errors 300, 300, 500, 300 → `phase_sel` = 0, because ties keep the lower phase.
- After lock at 100: windows return 150, 250, 250 → loss declared after the second 250; `relock_cnt` = 1; `busy` rises and `phase_sel` = 0 on the next edge.
- `manual_en` = 1 with `manual_ph` = 3 during MEAS → `phase_sel` = 3 the next cycle, `busy` = 0, `locked` = 0; `start` pulses are ignored.
- Assert `reset_n` low mid-search (phase 1, SETTLE) → all outputs go to 0 immediately; `start` afterwards begins a clean search at phase 0.
- `start` coincident with `win_v` in IDLE → search begins and the coincident window is not counted (checked via the per-phase window count).
